// File: rtl/tc_multi_dispatch_fsm.sv
// Multi-core task controller: accepts one SN workload, splits it into fixed-stride
// items, dispatches them to SIMD cores and runs bounded prefetch on PF cores.
module tc_multi_dispatch_fsm #(
  parameter int ADDR_WIDTH  = 64,
  parameter int WL_LEN_BITS = 32,
  parameter int N_SIMD      = 4,
  parameter int N_PF        = 2,
  parameter int ITEM_BYTES  = 64,
  parameter int PF_AHEAD    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         next_op_i,
  input  logic [ADDR_WIDTH-1:0]        next_addr_i,
  input  logic [WL_LEN_BITS-1:0]       next_len_i,
  output logic                         clr_next_o,
  output logic                         req_done_o,
  input  logic [ADDR_WIDTH-1:0]        simd_kernel_ptr_i,
  input  logic [N_SIMD-1:0]            simd_done_i,
  output logic [N_SIMD-1:0]            simd_reset_o,
  output logic [N_SIMD*ADDR_WIDTH-1:0] simd_g_arg_ptr_o,
  output logic [N_SIMD*ADDR_WIDTH-1:0] simd_l_arg_ptr_o,
  output logic [N_SIMD*ADDR_WIDTH-1:0] simd_ptr_o,
  input  logic [N_PF-1:0]              pf_done_i,
  output logic [N_PF-1:0]              pf_reset_o,
  output logic [N_PF*ADDR_WIDTH-1:0]   pf_ptr_o
);

  // state    | meaning
  // IDLE     | waiting for an SN request
  // ACCEPT   | workload captured, clr_next pulsing, counters cleared
  // DISPATCH | issuing items to SIMD cores, prefetching ahead on PF cores
  // DRAIN    | all items issued, waiting for prefetch and cores to finish
  // DONE     | req_done pulsing
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACCEPT   = 3'd1,
    S_DISPATCH = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam int CNT_W  = WL_LEN_BITS + 1;
  localparam int PROD_W = ADDR_WIDTH + WL_LEN_BITS;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [WL_LEN_BITS-1:0] len_q, len_d;
  logic [WL_LEN_BITS-1:0] issue_q, issue_d;
  logic [WL_LEN_BITS-1:0] pf_idx_q, pf_idx_d;
  logic                   clr_next_q, clr_next_d;
  logic                   req_done_q, req_done_d;
  logic [N_SIMD-1:0]      simd_rst_q, simd_rst_d;
  logic [N_PF-1:0]        pf_rst_q, pf_rst_d;

  logic [ADDR_WIDTH-1:0] g_arg_q [N_SIMD];
  logic [ADDR_WIDTH-1:0] g_arg_d [N_SIMD];
  logic [ADDR_WIDTH-1:0] l_arg_q [N_SIMD];
  logic [ADDR_WIDTH-1:0] l_arg_d [N_SIMD];
  logic [ADDR_WIDTH-1:0] kptr_q  [N_SIMD];
  logic [ADDR_WIDTH-1:0] kptr_d  [N_SIMD];
  logic [ADDR_WIDTH-1:0] pfp_q   [N_PF];
  logic [ADDR_WIDTH-1:0] pfp_d   [N_PF];

  logic [N_SIMD-1:0] simd_gnt;
  logic [N_PF-1:0]   pf_gnt;
  logic [CNT_W-1:0]  pf_limit;
  logic              simd_go;
  logic              pf_go;
  logic              all_free;

  function automatic logic [ADDR_WIDTH-1:0] item_addr(
    input logic [ADDR_WIDTH-1:0]  base,
    input logic [WL_LEN_BITS-1:0] idx
  );
    logic [PROD_W-1:0] offs;
    offs = PROD_W'(idx) * PROD_W'(ITEM_BYTES);
    return base + offs[ADDR_WIDTH-1:0];
  endfunction

  // Free cores hold reset high, so the lowest set bit of the reset vector is the grant.
  assign simd_gnt = simd_rst_q & (~simd_rst_q + N_SIMD'(1));
  assign pf_gnt   = pf_rst_q & (~pf_rst_q + N_PF'(1));
  assign pf_limit = {1'b0, issue_q} + CNT_W'(PF_AHEAD);
  assign all_free = (&simd_rst_q) && (&pf_rst_q);

  assign simd_go = (state_q == S_DISPATCH) && (issue_q < len_q) && (|simd_rst_q);
  assign pf_go   = ((state_q == S_DISPATCH) || (state_q == S_DRAIN)) &&
                   (pf_idx_q < len_q) && ({1'b0, pf_idx_q} < pf_limit) && (|pf_rst_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (next_op_i) state_d = S_ACCEPT;
      S_ACCEPT:   state_d = (len_q == '0) ? S_DONE : S_DISPATCH;
      S_DISPATCH: if (issue_q == len_q) state_d = S_DRAIN;
      S_DRAIN:    if ((issue_q == len_q) && (pf_idx_q == len_q) && all_free) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    issue_d    = issue_q;
    pf_idx_d   = pf_idx_q;
    simd_rst_d = simd_rst_q;
    pf_rst_d   = pf_rst_q;
    g_arg_d    = g_arg_q;
    l_arg_d    = l_arg_q;
    kptr_d     = kptr_q;
    pfp_d      = pfp_q;
    clr_next_d = (state_q == S_IDLE) && next_op_i;
    req_done_d = (state_d == S_DONE);

    if ((state_q == S_IDLE) && next_op_i) begin
      base_d = next_addr_i;
      len_d  = next_len_i;
    end
    if (state_q == S_ACCEPT) begin
      issue_d  = '0;
      pf_idx_d = '0;
    end

    // A core reporting done this cycle is still in RUN, so it is never granted here.
    for (int k = 0; k < N_SIMD; k++) begin
      if (!simd_rst_q[k] && simd_done_i[k]) simd_rst_d[k] = 1'b1;
      if (simd_go && simd_gnt[k]) begin
        simd_rst_d[k] = 1'b0;
        g_arg_d[k]    = base_q;
        l_arg_d[k]    = item_addr(base_q, issue_q);
        kptr_d[k]     = simd_kernel_ptr_i;
      end
    end
    if (simd_go) issue_d = issue_q + WL_LEN_BITS'(1);

    for (int k = 0; k < N_PF; k++) begin
      if (!pf_rst_q[k] && pf_done_i[k]) pf_rst_d[k] = 1'b1;
      if (pf_go && pf_gnt[k]) begin
        pf_rst_d[k] = 1'b0;
        pfp_d[k]    = item_addr(base_q, pf_idx_q);
      end
    end
    if (pf_go) pf_idx_d = pf_idx_q + WL_LEN_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      len_q      <= '0;
      issue_q    <= '0;
      pf_idx_q   <= '0;
      clr_next_q <= 1'b0;
      req_done_q <= 1'b0;
      simd_rst_q <= '1;
      pf_rst_q   <= '1;
      for (int k = 0; k < N_SIMD; k++) begin
        g_arg_q[k] <= '0;
        l_arg_q[k] <= '0;
        kptr_q[k]  <= '0;
      end
      for (int k = 0; k < N_PF; k++) begin
        pfp_q[k] <= '0;
      end
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      pf_idx_q   <= pf_idx_d;
      clr_next_q <= clr_next_d;
      req_done_q <= req_done_d;
      simd_rst_q <= simd_rst_d;
      pf_rst_q   <= pf_rst_d;
      g_arg_q    <= g_arg_d;
      l_arg_q    <= l_arg_d;
      kptr_q     <= kptr_d;
      pfp_q      <= pfp_d;
    end
  end

  assign clr_next_o   = clr_next_q;
  assign req_done_o   = req_done_q;
  assign simd_reset_o = simd_rst_q;
  assign pf_reset_o   = pf_rst_q;

  for (genvar k = 0; k < N_SIMD; k++) begin : g_simd_out
    assign simd_g_arg_ptr_o[k*ADDR_WIDTH +: ADDR_WIDTH] = g_arg_q[k];
    assign simd_l_arg_ptr_o[k*ADDR_WIDTH +: ADDR_WIDTH] = l_arg_q[k];
    assign simd_ptr_o[k*ADDR_WIDTH +: ADDR_WIDTH]       = kptr_q[k];
  end

  for (genvar k = 0; k < N_PF; k++) begin : g_pf_out
    assign pf_ptr_o[k*ADDR_WIDTH +: ADDR_WIDTH] = pfp_q[k];
  end

endmodule

// File: tb/tb_tc_multi_dispatch_fsm.sv
// Bench for tc_multi_dispatch_fsm: random core completions against a workload-level
// model, plus hand-computed expectations for the directed scenarios.
module tb_tc_multi_dispatch_fsm;
  localparam int AW = 64;
  localparam int LW = 32;
  localparam int NS = 4;
  localparam int NP = 2;
  localparam int IB = 64;
  localparam int AH = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           next_op;
  logic [AW-1:0]  next_addr;
  logic [LW-1:0]  next_len;
  logic           clr_next;
  logic           req_done;
  logic [AW-1:0]  kptr;
  logic [NS-1:0]  simd_done;
  logic [NS-1:0]  simd_reset;
  logic [NS*AW-1:0] g_arg, l_arg, sptr;
  logic [NP-1:0]  pf_done;
  logic [NP-1:0]  pf_reset;
  logic [NP*AW-1:0] pf_ptr;

  tc_multi_dispatch_fsm #(
    .ADDR_WIDTH(AW), .WL_LEN_BITS(LW), .N_SIMD(NS), .N_PF(NP),
    .ITEM_BYTES(IB), .PF_AHEAD(AH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .next_op_i(next_op), .next_addr_i(next_addr), .next_len_i(next_len),
    .clr_next_o(clr_next), .req_done_o(req_done),
    .simd_kernel_ptr_i(kptr), .simd_done_i(simd_done), .simd_reset_o(simd_reset),
    .simd_g_arg_ptr_o(g_arg), .simd_l_arg_ptr_o(l_arg), .simd_ptr_o(sptr),
    .pf_done_i(pf_done), .pf_reset_o(pf_reset), .pf_ptr_o(pf_ptr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  // Workload-level model: phase 0 idle, 1 accepted, 2 issuing, 3 draining, 4 finished.
  int               m_phase;
  longint unsigned  m_base;
  longint unsigned  m_len, m_issue, m_pf;
  bit               m_srun [NS];
  bit               m_prun [NP];
  longint unsigned  m_g [NS], m_l [NS], m_k [NS], m_pp [NP];
  bit               m_clr, m_done;

  function automatic void model_reset();
    m_phase = 0; m_base = 0; m_len = 0; m_issue = 0; m_pf = 0;
    m_clr = 0; m_done = 0;
    for (int k = 0; k < NS; k++) begin m_srun[k] = 0; m_g[k] = 0; m_l[k] = 0; m_k[k] = 0; end
    for (int k = 0; k < NP; k++) begin m_prun[k] = 0; m_pp[k] = 0; end
  endfunction

  function automatic void model_step();
    int nphase;
    bit srun_n [NS];
    bit prun_n [NP];
    bit idle_all;
    longint unsigned issue_old;
    bit placed;
    nphase = m_phase;
    idle_all = 1;
    for (int k = 0; k < NS; k++) begin
      srun_n[k] = m_srun[k] && !simd_done[k];
      if (m_srun[k]) idle_all = 0;
    end
    for (int k = 0; k < NP; k++) begin
      prun_n[k] = m_prun[k] && !pf_done[k];
      if (m_prun[k]) idle_all = 0;
    end
    m_clr = 0;
    issue_old = m_issue;
    case (m_phase)
      0: if (next_op) begin m_base = next_addr; m_len = 64'(next_len); nphase = 1; m_clr = 1; end
      1: begin m_issue = 0; m_pf = 0; issue_old = 0; nphase = (m_len == 0) ? 4 : 2; end
      2: if (m_issue == m_len) nphase = 3;
      3: if (m_issue == m_len && m_pf == m_len && idle_all) nphase = 4;
      default: nphase = 0;
    endcase
    if (m_phase == 2 && m_issue < m_len) begin
      placed = 0;
      for (int k = 0; k < NS; k++) begin
        if (!placed && !m_srun[k]) begin
          placed = 1;
          srun_n[k] = 1;
          m_g[k] = m_base;
          m_l[k] = m_base + m_issue * 64'(IB);
          m_k[k] = kptr;
        end
      end
      if (placed) m_issue++;
    end
    if ((m_phase == 2 || m_phase == 3) && m_pf < m_len && m_pf < issue_old + 64'(AH)) begin
      placed = 0;
      for (int k = 0; k < NP; k++) begin
        if (!placed && !m_prun[k]) begin
          placed = 1;
          prun_n[k] = 1;
          m_pp[k] = m_base + m_pf * 64'(IB);
        end
      end
      if (placed) m_pf++;
    end
    m_done = (nphase == 4);
    m_phase = nphase;
    m_srun = srun_n;
    m_prun = prun_n;
  endfunction

  task automatic compare_all();
    logic [NS-1:0] exp_sr;
    logic [NP-1:0] exp_pr;
    for (int k = 0; k < NS; k++) exp_sr[k] = !m_srun[k];
    for (int k = 0; k < NP; k++) exp_pr[k] = !m_prun[k];
    check("clr_next", 64'(clr_next), 64'(m_clr));
    check("req_done", 64'(req_done), 64'(m_done));
    check("simd_reset", 64'(simd_reset), 64'(exp_sr));
    check("pf_reset", 64'(pf_reset), 64'(exp_pr));
    for (int k = 0; k < NS; k++) begin
      check($sformatf("g_arg%0d", k), g_arg[k*AW +: AW], m_g[k]);
      check($sformatf("l_arg%0d", k), l_arg[k*AW +: AW], m_l[k]);
      check($sformatf("simd_ptr%0d", k), sptr[k*AW +: AW], m_k[k]);
    end
    for (int k = 0; k < NP; k++) check($sformatf("pf_ptr%0d", k), pf_ptr[k*AW +: AW], m_pp[k]);
  endtask

  // Observed dispatches (reset falling edges) per workload and req_done pulses.
  int obs_s = 0, obs_p = 0, n_rd = 0;
  logic [NS-1:0] prev_sr = '1;
  logic [NP-1:0] prev_pr = '1;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      compare_all();
      if (clr_next) begin obs_s = 0; obs_p = 0; end
      obs_s += $countones(prev_sr & ~simd_reset);
      if ((prev_pr & ~pf_reset) != '0) begin
        obs_p += $countones(prev_pr & ~pf_reset);
        check("pf_ahead_bound", 64'(obs_p <= obs_s + AH), 64'd1);
      end
      if (req_done) n_rd++;
      prev_sr = simd_reset;
      prev_pr = pf_reset;
    end
  end

  // Done drivers: 0 random, 1 held low, 2 driven by the main sequence.
  int mode_s = 1, mode_p = 1;
  always @(negedge clk) begin
    kptr = {$urandom, $urandom};
    if (mode_s == 0) for (int k = 0; k < NS; k++) simd_done[k] = ($urandom_range(0, 3) == 0);
    else if (mode_s == 1) simd_done = '0;
    if (mode_p == 0) for (int k = 0; k < NP; k++) pf_done[k] = ($urandom_range(0, 3) == 0);
    else if (mode_p == 1) pf_done = '0;
  end

  task automatic start_req(input logic [AW-1:0] addr, input logic [LW-1:0] len, output int lat);
    @(negedge clk);
    next_op = 1'b1; next_addr = addr; next_len = len;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (clr_next) break;
    end
    check("clr_next_seen", 64'(clr_next), 64'd1);
    @(negedge clk);
    next_op = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (req_done) begin seen = 1; break; end
    end
    check("req_done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, rd0;
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rd0;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    next_op = 0; next_addr = '0; next_len = '0;
    simd_done = '0; pf_done = '0; kptr = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_simd_reset", 64'(simd_reset), 64'hF);
    check("rst_pf_reset", 64'(pf_reset), 64'h3);
    check("rst_l_arg0", l_arg[0 +: AW], 64'h0);
    check("rst_clr_next", 64'(clr_next), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // len = 0: accept then immediate completion, no core touched
    start_req(64'h1000, 32'd0, lat);
    check("t1_clr_latency", 64'(lat), 64'd1);
    @(posedge clk); #1;
    check("t1_req_done_T2", 64'(req_done), 64'd1);
    @(posedge clk); #1;
    check("t1_req_done_once", 64'(req_done), 64'd0);
    check("t1_no_simd_issue", 64'(obs_s), 64'd0);
    check("t1_no_pf_issue", 64'(obs_p), 64'd0);

    // len = 6 on four cores, then two cores finishing together
    mode_s = 2; simd_done = '0; mode_p = 1;
    rd0 = n_rd;
    start_req(64'h1000, 32'd6, lat);
    repeat (6) @(posedge clk);
    #1;
    check("t2_simd_reset", 64'(simd_reset), 64'h0);
    check("t2_l_arg0", l_arg[0*AW +: AW], 64'h1000);
    check("t2_l_arg1", l_arg[1*AW +: AW], 64'h1040);
    check("t2_l_arg2", l_arg[2*AW +: AW], 64'h1080);
    check("t2_l_arg3", l_arg[3*AW +: AW], 64'h10C0);
    check("t2_g_arg3", g_arg[3*AW +: AW], 64'h1000);
    check("t2_pf_ptr0", pf_ptr[0*AW +: AW], 64'h1000);
    check("t2_pf_ptr1", pf_ptr[1*AW +: AW], 64'h1040);
    @(negedge clk) simd_done = 4'b0110;
    @(posedge clk); #1;
    check("t3_both_free", 64'(simd_reset), 64'h6);
    @(negedge clk) simd_done = '0;
    @(posedge clk); #1;
    check("t3_core1_first", 64'(simd_reset), 64'h4);
    check("t3_core1_item4", l_arg[1*AW +: AW], 64'h1100);
    @(posedge clk); #1;
    check("t3_core2_next", 64'(simd_reset), 64'h0);
    check("t3_core2_item5", l_arg[2*AW +: AW], 64'h1140);
    mode_s = 0; mode_p = 0;
    wait_done(500);
    check("t2_one_req_done", 64'(n_rd - rd0), 64'd1);

    // prefetch bound with SIMD stalled after four issues
    mode_s = 1; mode_p = 0;
    rd0 = n_rd;
    start_req(64'h2000, 32'd8, lat);
    repeat (80) @(posedge clk);
    #1;
    check("t4_simd_issued", 64'(obs_s), 64'd4);
    check("t4_pf_stops_at_6", 64'(obs_p), 64'd6);
    mode_s = 0;
    wait_done(500);
    check("t4_one_req_done", 64'(n_rd - rd0), 64'd1);

    // address wrap
    mode_s = 1; mode_p = 1;
    start_req(64'hFFFF_FFFF_FFFF_FFC0, 32'd2, lat);
    repeat (4) @(posedge clk);
    #1;
    check("t5_l_arg0", l_arg[0*AW +: AW], 64'hFFFF_FFFF_FFFF_FFC0);
    check("t5_l_arg1_wrap", l_arg[1*AW +: AW], 64'h0);
    mode_s = 0; mode_p = 0;
    wait_done(500);

    // reset in the middle of a workload
    mode_s = 1; mode_p = 1;
    rd0 = n_rd;
    start_req(64'h3000, 32'd8, lat);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("t6_simd_reset", 64'(simd_reset), 64'hF);
    check("t6_pf_reset", 64'(pf_reset), 64'h3);
    check("t6_l_arg0", l_arg[0*AW +: AW], 64'h0);
    check("t6_pf_ptr0", pf_ptr[0*AW +: AW], 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_no_req_done", 64'(n_rd - rd0), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    mode_s = 0; mode_p = 0;
    rd0 = n_rd;
    start_req(64'h4000, 32'd5, lat);
    wait_done(500);
    check("t6_after_reset_done", 64'(n_rd - rd0), 64'd1);

    // random workloads
    for (int w = 0; w < 20; w++) begin
      base = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255)))
                                         : {$urandom, $urandom};
      len  = 32'($urandom_range(0, 12));
      mode_s = ($urandom_range(0, 4) == 0) ? 2 : 0;
      if (mode_s == 2) simd_done = '1;
      mode_p = 0;
      rd0 = n_rd;
      start_req(base, len, lat);
      mode_s = 0;
      wait_done(600);
      check("rand_one_req_done", 64'(n_rd - rd0), 64'd1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
